// File: rtl/rr_lock_arbiter.sv
// Round-robin arbiter with grant locking: the owner keeps the resource until it drops req.
// Optional hold limit (forced rotation after MAX_HOLD cycles) enabled by defining ARB_HOLD_LIMIT_EN.
module rr_lock_arbiter #(
    parameter int N        = 4,
    parameter int IW       = 2,
    parameter int MAX_HOLD = 16
) (
    input  logic [1:0]    clock_reset,
    input  logic [N-1:0]  req,
    output logic [N-1:0]  grant,
    output logic          grant_valid,
    output logic [IW-1:0] grant_idx,
    output logic          any_req,
    output logic          preempt
);

    typedef enum logic {IDLE, BUSY} state_t;

    logic clk;
    logic srst;
    assign clk  = clock_reset[0];
    assign srst = clock_reset[1];

    generate
        if (N < 2 || N > 16 || IW != $clog2(N) || MAX_HOLD < 1 || MAX_HOLD > 255) begin : g_bad_params
            $error("rr_lock_arbiter: illegal parameter combination");
        end
    endgenerate

    state_t        state_reg, state_next;
    logic [IW-1:0] ptr_reg, ptr_next;
    logic [IW-1:0] idx_reg, idx_next;
    logic          valid_reg, valid_next;
    logic [N-1:0]  grant_reg, grant_next;
    logic          any_req_reg;
    logic [IW-1:0] inc_idx;
    logic [IW-1:0] search_ptr;
    logic [IW-1:0] pos;
    logic [IW-1:0] win_idx;
    logic          win_found;

`ifdef ARB_HOLD_LIMIT_EN
    logic [7:0] hold_reg, hold_next, hold_inc;
    logic       preempt_reg, preempt_next;
    logic       others_pending;

    assign hold_inc       = (hold_reg == 8'(MAX_HOLD)) ? hold_reg : hold_reg + 8'd1;
    assign others_pending = |(req & ~grant_reg);
`endif

    assign inc_idx = (idx_reg == IW'(N - 1)) ? '0 : idx_reg + 1'b1;

    // In BUSY the only searches that matter (release or forced rotation) start just past the owner.
    always_comb begin
        search_ptr = (state_reg == BUSY) ? inc_idx : ptr_reg;
        win_found  = 1'b0;
        win_idx    = search_ptr;
        pos        = search_ptr;
        for (int i = N - 1; i >= 0; i--) begin
            pos = IW'((int'(search_ptr) + i) % N);
            if (req[pos]) begin
                win_found = 1'b1;
                win_idx   = pos;
            end
        end
    end

    always_comb begin
        state_next = state_reg;
        ptr_next   = ptr_reg;
        idx_next   = idx_reg;
        valid_next = valid_reg;
`ifdef ARB_HOLD_LIMIT_EN
        hold_next    = hold_reg;
        preempt_next = 1'b0;
`endif
        case (state_reg)
            IDLE: begin
                if (win_found) begin
                    idx_next   = win_idx;
                    valid_next = 1'b1;
                    state_next = BUSY;
`ifdef ARB_HOLD_LIMIT_EN
                    hold_next  = 8'd0;
`endif
                end
            end
            BUSY: begin
                if (!req[idx_reg]) begin
                    ptr_next = inc_idx;
                    if (win_found) begin
                        idx_next = win_idx;
`ifdef ARB_HOLD_LIMIT_EN
                        hold_next = 8'd0;
`endif
                    end else begin
                        valid_next = 1'b0;
                        state_next = IDLE;
                    end
                end
`ifdef ARB_HOLD_LIMIT_EN
                else if (hold_inc == 8'(MAX_HOLD) && others_pending) begin
                    ptr_next     = inc_idx;
                    idx_next     = win_idx;
                    hold_next    = 8'd0;
                    preempt_next = 1'b1;
                end else begin
                    hold_next = hold_inc;
                end
`endif
            end
            default: state_next = IDLE;
        endcase
    end

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_grant
            assign grant_next[gi] = valid_next && (idx_next == IW'(gi));
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (srst) begin
            state_reg   <= IDLE;
            ptr_reg     <= '0;
            idx_reg     <= '0;
            valid_reg   <= 1'b0;
            grant_reg   <= '0;
            any_req_reg <= 1'b0;
`ifdef ARB_HOLD_LIMIT_EN
            hold_reg    <= 8'd0;
            preempt_reg <= 1'b0;
`endif
        end else begin
            state_reg   <= state_next;
            ptr_reg     <= ptr_next;
            idx_reg     <= idx_next;
            valid_reg   <= valid_next;
            grant_reg   <= grant_next;
            any_req_reg <= |req;
`ifdef ARB_HOLD_LIMIT_EN
            hold_reg    <= hold_next;
            preempt_reg <= preempt_next;
`endif
        end
    end

    assign grant       = grant_reg;
    assign grant_valid = valid_reg;
    assign grant_idx   = idx_reg;
    assign any_req     = any_req_reg;
`ifdef ARB_HOLD_LIMIT_EN
    assign preempt     = preempt_reg;
`else
    assign preempt     = 1'b0;
`endif

endmodule

// File: doc/rr_lock_arbiter.md
Name: rr_lock_arbiter

Overview:
- Round-robin arbiter with grant locking.
- Shares a single downstream resource (register, FIFO write port, bus) among N requesters.
- Sits between requester blocks and the shared datapath. Drives the resource's select and enable.
- Also exports a registered "any request pending" flag for upstream power/idle logic.

Parameters:
- N, 4, number of requesters; legal range 2..16.
- IW, 2, grant index width; must equal ceil(log2(N)).
- MAX_HOLD, 16, hold-limit cycle count; used only when ARB_HOLD_LIMIT_EN is defined; legal range 1..255.

Ports:
- clock_reset  input  2  packed clock/reset: bit 0 = clock, bit 1 = reset. One clock domain. Reset is synchronous and active-high.
- req  input  N  per-requester request. Level-sensitive. Held high for the whole transaction.
- grant  output  N  registered one-hot grant; all-zero when no owner.
- grant_valid  output  1  registered; equals OR of grant.
- grant_idx  output  IW  registered binary index of the owner; holds the last owner when grant_valid=0.
- any_req  output  1  registered OR of req, sampled at the previous edge.
- preempt  output  1  registered one-cycle pulse on forced rotation; tied 0 without ARB_HOLD_LIMIT_EN.

Behaviour:
- All state updates on the rising edge of clock_reset[0].
- Reset: sampled high at an edge. Next values: grant=0, grant_valid=0, grant_idx=0, any_req=0, preempt=0, ptr=0, state=IDLE, hold counter=0.
- Reset overrides everything else in the same cycle. If reset arrives mid-transaction, grant drops at that edge and the priority pointer returns to 0.
- Priority pointer ptr (IW bits): the search starts at ptr and wraps N-1 -> 0. The first set req bit wins.
- State IDLE:
  - If req != 0, load grant with the one-hot winner and set grant_idx and grant_valid. Go to BUSY.
  - Latency: req sampled at edge k gives grant visible after edge k.
- State BUSY:
  - While req[grant_idx]=1, hold grant unchanged (lock). Other requests are ignored.
  - When req[grant_idx]=0 is sampled: ptr <= (grant_idx+1) mod N.
    - If any other req is set, the search runs with that new ptr in the same cycle. The winner is granted at that edge: back-to-back handoff, zero dead cycles, stay in BUSY.
    - Else clear grant and grant_valid, go to IDLE.
- A requester that releases and re-asserts in consecutive cycles loses priority to every other pending requester.
- Single requester: a constant req=0001 gets grant=0001 forever. No glitch, no rotation.
- Wrap-around: owner N-1 releasing sets ptr=0.
- grant is always one-hot or zero. grant_valid==|grant at every cycle.
- A req bit dropping for a non-owner has no effect.

Optional Feature:
- Macro: ARB_HOLD_LIMIT_EN.
- Defined:
  - A hold counter increments each cycle in BUSY while the owner keeps req high. It resets on every new grant.
  - When the count reaches MAX_HOLD and any other req is set, the owner is forcibly released:
    - ptr <= owner+1.
    - The next winner is granted at that edge.
    - preempt pulses 1 for one cycle.
  - The preempted requester keeps its req high and is re-arbitrated normally.
  - If no other req is set, the counter saturates at MAX_HOLD and the owner keeps the grant.
- Undefined:
  - No counter. Lock is unbounded. preempt is constant 0.

Test Plan:
- Reset: assert clock_reset[1] for 2 edges with req=1111, then release -> during reset grant=0000, grant_valid=0, grant_idx=0. One edge after release grant=0001.
- Round-robin: req=1111 held; each owner drops its req for one cycle in turn -> grant sequence 0001, 0010, 0100, 1000, 0001 with zero idle cycles between owners.
- Lock: owner 2 holds req for 10 cycles while req[0], req[3] are high -> grant stays 0100 for 10 cycles. Then grant=1000 (ptr=3 wins over 0).
- Reset mid-transaction: grant=0100 active, reset one edge -> grant=0000 that edge. After release with req=0110, grant=0010.
- Idle/any: req goes 0000 -> 0000 -> 0100 -> grant 0000, 0000, then 0100 one edge later. any_req follows req delayed one edge.
- With ARB_HOLD_LIMIT_EN, MAX_HOLD=4: req=0011 held constant -> grant 0001 for 4 cycles, then 0010 with preempt=1 for one cycle. Grant alternates every 4 cycles thereafter.
